status_flag_unit: RTL and testbench
===================================

# status_flag_unit

Clocked, parametrised successor to the datapath's NZV flag latch. Holds an NFLAGS-wide status word with per-bit write masking, adds a carry flag, and adds a hardware save/restore stack for nested exception/interrupt entry. Also evaluates 4-bit branch condition codes against the live flags for the branch unit. Sits between the ALU flag outputs and the control/branch logic.

## Interface
Parameters:
- NFLAGS, 4: status word width; must be ≥ 4. Bit 0 = Z, bit 1 = N, bit 2 = C, bit 3 = V; bits above 3 are general-purpose user flags.
- STACK_DEPTH, 4: number of saved flag words; must be ≥ 1.
- CNT_W, $clog2(STACK_DEPTH+1): width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- en  in  1  flag update strobe from control
- flag_mask  in  NFLAGS  per-bit update enable, qualified by en
- flags_in  in  NFLAGS  new flag values from ALU
- push  in  1  save live flags onto stack
- pop  in  1  restore live flags from top of stack
- clear_err  in  1  clear sticky error bits
- cond  in  4  condition code to evaluate
- flags_out  out  NFLAGS  live flag register
- cond_true  out  1  condition result, combinational from flags_out and cond
- depth  out  CNT_W  stack occupancy
- full  out  1  depth == STACK_DEPTH
- empty  out  1  depth == 0
- ovf_err  out  1  sticky: push attempted while full
- unf_err  out  1  sticky: pop attempted while empty, or push and pop in the same cycle

## Operation
- Update: when en=1 and no pop takes effect, each bit i with flag_mask[i]=1 loads flags_in[i]; unmasked bits hold. en=0 holds all bits. This replaces the latch behaviour of the previous block.
- Push, when push=1, pop=0, !full: stack[depth] ← current flags_out (pre-update value); depth+1. A same-cycle en update still applies to the live register.
- Push while full: stack and depth unchanged, ovf_err ← 1; en update still applies.
- Pop, when pop=1, push=0, !empty: flags_out ← stack[depth-1]; depth−1. Pop has priority over en, so the update is discarded that cycle.
- Pop while empty: stack, depth and flags_out unchanged except that a same-cycle en update applies; unf_err ← 1.
- push=1 and pop=1 together: illegal. No stack change, depth unchanged, unf_err ← 1, en update applies.
- clear_err=1 clears both sticky bits. If a new error occurs in the same cycle, the set wins.
- Condition codes, with Z=flags_out[0], N=[1], C=[2], V=[3]:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- Stack storage is a plain register array with no reset. Only depth defines validity.

## Timing
- Reset, synchronous with rst=1 at the edge: flags_out=0, depth=0, full=0, empty=1, ovf_err=0, unf_err=0. rst overrides all other inputs that cycle.
- Reset mid-operation discards all stacked entries. Stale array contents must never reach flags_out after reset.
- Update latency: 1 cycle. flags_in sampled at edge k appears on flags_out after edge k.
- Push/pop: depth, full and empty reflect the operation after the same edge. A pop's restored value is visible the cycle after the edge.
- Back-to-back push then pop on consecutive cycles returns exactly the pushed word, including an en update made in the push cycle being overwritten by the pop.
- cond_true has zero latency from cond and flags_out, with no register stage. It reflects the flags after the last edge, not same-cycle flags_in.
- full, empty and the error bits are registered or derived from registered depth only. There is no combinational path from push or pop to these outputs.

## Test plan
- Reset/masked update: rst, then en=1, mask=0101, flags_in=1111 → flags_out=0101 next cycle. Then en=0, flags_in=0000 → flags_out holds 0101.
- Push/update/pop: flags=0011; push with en=1, mask=1111, flags_in=1100 → flags_out=1100, depth=1. Then pop with en=1, flags_in=0000 → flags_out=0011, depth=0, empty=1.
- Fill/overflow (STACK_DEPTH=4): push ×4 with distinct words A,B,C,D → full=1. 5th push → ovf_err=1, depth=4. Pop ×4 returns D,C,B,A in order.
- Underflow/illegal: pop while empty → unf_err=1, flags_out unchanged. clear_err → 0. push+pop same cycle with depth=2 → depth stays 2, unf_err=1.
- Condition sweep: all 16 NZCV combinations × 16 cond values → cond_true matches the encoding list. Spot check NZCV: N=1, V=0, Z=0 → GE=0, LT=1, GT=0, LE=1.
- Reset mid-stack: depth=3, assert rst → depth=0, empty=1, flags_out=0. Subsequent pop → unf_err=1, flags_out stays 0.

Source files
------------

// File: rtl/status_flag_unit.sv
// ---------------------------------------------------------------------------
// status_flag_unit
//
// Holds the live NFLAGS-wide status word (Z, N, C, V plus user flags) with
// per-bit masked updates. It also keeps a small save/restore stack for nested
// exception entry and evaluates 4-bit branch condition codes against the
// live flags.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   en         flag update strobe
//   flag_mask  per-bit update enable, qualified by en
//   flags_in   new flag values from the ALU
//   push       save live flags onto the stack
//   pop        restore live flags from the top of the stack
//   clear_err  clear the sticky error bits
//   cond       condition code to evaluate
//   flags_out  live flag register
//   cond_true  combinational condition result from flags_out and cond
//   depth      stack occupancy
//   full       depth == STACK_DEPTH
//   empty      depth == 0
//   ovf_err    sticky: push attempted while full
//   unf_err    sticky: pop while empty, or push and pop together
// ---------------------------------------------------------------------------
module status_flag_unit #(
  parameter int NFLAGS      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NFLAGS-1:0] flag_mask,
  input  logic [NFLAGS-1:0] flags_in,
  input  logic              push,
  input  logic              pop,
  input  logic              clear_err,
  input  logic [3:0]        cond,
  output logic [NFLAGS-1:0] flags_out,
  output logic              cond_true,
  output logic [CNT_W-1:0]  depth,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic              ovfErr_q, ovfErr_d;
  logic              unfErr_q, unfErr_d;

  logic [NFLAGS-1:0] stackMem [STACK_DEPTH];

  logic              isFull, isEmpty;
  logic              doPush, doPop;
  logic              pushWhileFull, popWhileEmpty, pushAndPop;
  logic [CNT_W-1:0]  depthMinusOne;
  logic [IDX_W-1:0]  wrIdx, rdIdx;

  // Occupancy flags come only from the registered depth, so push and pop
  // never reach full/empty combinationally.
  assign isFull  = (depth_q == CNT_W'(STACK_DEPTH));
  assign isEmpty = (depth_q == '0);

  // Classify the stack request. A push with pop together is illegal and
  // does nothing to the stack, only raising the underflow error.
  assign doPush        = push & ~pop & ~isFull;
  assign doPop         = pop & ~push & ~isEmpty;
  assign pushWhileFull = push & ~pop & isFull;
  assign popWhileEmpty = pop & ~push & isEmpty;
  assign pushAndPop    = push & pop;

  // The write slot is the current depth and the read slot is the one below
  // it. The truncated indices are only used when the matching operation is
  // legal, so they always land inside the array.
  assign depthMinusOne = depth_q - CNT_W'(1);
  assign wrIdx         = depth_q[IDX_W-1:0];
  assign rdIdx         = depthMinusOne[IDX_W-1:0];

  // Next-state logic. A legal pop restores the saved word and overrides any
  // same-cycle en update. Otherwise en loads only the masked bits. New
  // errors win over clear_err so that a fault in the clearing cycle is
  // never lost.
  always_comb begin
    flags_d  = flags_q;
    depth_d  = depth_q;
    ovfErr_d = ovfErr_q & ~clear_err;
    unfErr_d = unfErr_q & ~clear_err;

    if (doPop) begin
      flags_d = stackMem[rdIdx];
      depth_d = depthMinusOne;
    end else if (en) begin
      flags_d = (flags_q & ~flag_mask) | (flags_in & flag_mask);
    end

    if (doPush) begin
      depth_d = depth_q + CNT_W'(1);
    end

    if (pushWhileFull) begin
      ovfErr_d = 1'b1;
    end
    if (popWhileEmpty || pushAndPop) begin
      unfErr_d = 1'b1;
    end
  end

  // Control state register. Reset clears the live flags and the occupancy.
  // With depth at zero, stale stack words can never be restored afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= '0;
      depth_q  <= '0;
      ovfErr_q <= 1'b0;
      unfErr_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      depth_q  <= depth_d;
      ovfErr_q <= ovfErr_d;
      unfErr_q <= unfErr_d;
    end
  end

  // Stack storage has no reset; depth alone says which entries are valid.
  // A push saves the pre-update live flags, so an en update made in the
  // same cycle only affects the live register.
  always_ff @(posedge clk) begin
    if (!rst && doPush) begin
      stackMem[wrIdx] <= flags_q;
    end
  end

  // Branch condition evaluation straight from the registered flags, with
  // no register stage in between.
  always_comb begin
    logic z, n, c, v;
    z = flags_q[0];
    n = flags_q[1];
    c = flags_q[2];
    v = flags_q[3];
    cond_true = 1'b0;
    unique case (cond)
      4'd0:  cond_true = z;
      4'd1:  cond_true = ~z;
      4'd2:  cond_true = c;
      4'd3:  cond_true = ~c;
      4'd4:  cond_true = n;
      4'd5:  cond_true = ~n;
      4'd6:  cond_true = v;
      4'd7:  cond_true = ~v;
      4'd8:  cond_true = c & ~z;
      4'd9:  cond_true = ~c | z;
      4'd10: cond_true = (n == v);
      4'd11: cond_true = (n != v);
      4'd12: cond_true = ~z & (n == v);
      4'd13: cond_true = z | (n != v);
      4'd14: cond_true = 1'b1;
      4'd15: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign flags_out = flags_q;
  assign depth     = depth_q;
  assign full      = isFull;
  assign empty     = isEmpty;
  assign ovf_err   = ovfErr_q;
  assign unf_err   = unfErr_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_status_flag_unit
//
// Directed steps followed by random traffic for status_flag_unit. A queue
// based reference model keeps the expected flags, stack contents and sticky
// errors. Each observation is an immediate assertion.
// ---------------------------------------------------------------------------
module tb_status_flag_unit;

  localparam int NFLAGS      = 4;
  localparam int STACK_DEPTH = 4;
  localparam int CNT_W       = $clog2(STACK_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, en, push, pop, clear_err;
  logic [NFLAGS-1:0] flag_mask, flags_in;
  logic [3:0]        cond;
  logic [NFLAGS-1:0] flags_out;
  logic              cond_true, full, empty, ovf_err, unf_err;
  logic [CNT_W-1:0]  depth;

  int nAsserts = 0;
  int nFails   = 0;

  // Reference model state
  logic [3:0] mFlags;
  logic [3:0] mStack [$];
  logic       mOvf, mUnf;

  status_flag_unit #(
    .NFLAGS(NFLAGS), .STACK_DEPTH(STACK_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flag_mask(flag_mask), .flags_in(flags_in),
    .push(push), .pop(pop), .clear_err(clear_err), .cond(cond),
    .flags_out(flags_out), .cond_true(cond_true), .depth(depth),
    .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  // Condition code table evaluated from named flag values
  function automatic logic condRef(input logic [3:0] fl, input logic [3:0] c);
    logic z, n, cy, v;
    z = fl[0]; n = fl[1]; cy = fl[2]; v = fl[3];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs sampled at the edge
  task automatic modelUpdate();
    logic [3:0] old;
    logic newOvf, newUnf;
    int sz;
    if (rst) begin
      mFlags = '0;
      mStack.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else begin
      sz     = mStack.size();
      old    = mFlags;
      newOvf = push && !pop && (sz == STACK_DEPTH);
      newUnf = (pop && !push && (sz == 0)) || (push && pop);
      if (pop && !push && sz > 0) begin
        mFlags = mStack.pop_back();
      end else if (en) begin
        for (int i = 0; i < 4; i++)
          if (flag_mask[i]) mFlags[i] = flags_in[i];
      end
      if (push && !pop && sz < STACK_DEPTH) mStack.push_back(old);
      mOvf = newOvf ? 1'b1 : (clear_err ? 1'b0 : mOvf);
      mUnf = newUnf ? 1'b1 : (clear_err ? 1'b0 : mUnf);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".flags"}, 32'(flags_out), 32'(mFlags));
    check({tag, ".depth"}, 32'(depth), 32'(mStack.size()));
    check({tag, ".full"},  32'(full),  32'(mStack.size() == STACK_DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(mStack.size() == 0));
    check({tag, ".ovf"},   32'(ovf_err), 32'(mOvf));
    check({tag, ".unf"},   32'(unf_err), 32'(mUnf));
    check({tag, ".cond"},  32'(cond_true), 32'(condRef(mFlags, cond)));
  endtask

  // Drive one cycle of inputs, clock it, then check just after the edge
  task automatic applyStimulus(input string tag, input logic r, input logic e,
                               input logic [3:0] m, input logic [3:0] f,
                               input logic pu, input logic po, input logic cl,
                               input logic [3:0] c);
    rst = r; en = e; flag_mask = m; flags_in = f;
    push = pu; pop = po; clear_err = cl; cond = c;
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flag_mask = '0; flags_in = '0;
    push = 1'b0; pop = 1'b0; clear_err = 1'b0; cond = '0;
    mFlags = '0; mOvf = 1'b0; mUnf = 1'b0;
    #2;

    // Reset and masked update
    applyStimulus("reset", 1, 0, 4'h0, 4'h0, 0, 0, 0, 4'd0);
    check("reset.flags0", 32'(flags_out), 32'h0);
    check("reset.empty1", 32'(empty), 32'h1);
    applyStimulus("mask", 0, 1, 4'b0101, 4'b1111, 0, 0, 0, 4'd0);
    check("mask.flags0101", 32'(flags_out), 32'h5);
    applyStimulus("hold", 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'd1);
    check("hold.flags0101", 32'(flags_out), 32'h5);

    // Push with same-cycle update, then pop discarding the update
    applyStimulus("ld0011", 0, 1, 4'hF, 4'b0011, 0, 0, 0, 4'd2);
    applyStimulus("pushUpd", 0, 1, 4'hF, 4'b1100, 1, 0, 0, 4'd3);
    check("pushUpd.flags", 32'(flags_out), 32'hC);
    check("pushUpd.depth", 32'(depth), 32'h1);
    applyStimulus("popUpd", 0, 1, 4'hF, 4'b0000, 0, 1, 0, 4'd4);
    check("popUpd.flags", 32'(flags_out), 32'h3);
    check("popUpd.empty", 32'(empty), 32'h1);

    // Fill and overflow: stack receives A,B,C,D
    applyStimulus("ldA", 0, 1, 4'hF, 4'hA, 0, 0, 0, 4'd5);
    applyStimulus("pushA", 0, 1, 4'hF, 4'hB, 1, 0, 0, 4'd6);
    applyStimulus("pushB", 0, 1, 4'hF, 4'hC, 1, 0, 0, 4'd7);
    applyStimulus("pushC", 0, 1, 4'hF, 4'hD, 1, 0, 0, 4'd8);
    applyStimulus("pushD", 0, 1, 4'hF, 4'h6, 1, 0, 0, 4'd9);
    check("fill.full", 32'(full), 32'h1);
    applyStimulus("push5", 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'd10);
    check("push5.ovf", 32'(ovf_err), 32'h1);
    check("push5.depth", 32'(depth), 32'h4);
    applyStimulus("popD", 0, 0, 4'h0, 4'h0, 0, 1, 0, 4'd11);
    check("popD.flags", 32'(flags_out), 32'hD);
    applyStimulus("popC", 0, 0, 4'h0, 4'h0, 0, 1, 0, 4'd12);
    check("popC.flags", 32'(flags_out), 32'hC);
    applyStimulus("popB", 0, 0, 4'h0, 4'h0, 0, 1, 0, 4'd13);
    check("popB.flags", 32'(flags_out), 32'hB);
    applyStimulus("popA", 0, 0, 4'h0, 4'h0, 0, 1, 1, 4'd14);
    check("popA.flags", 32'(flags_out), 32'hA);

    // Underflow, clear, illegal push+pop
    applyStimulus("popEmpty", 0, 0, 4'h0, 4'h0, 0, 1, 0, 4'd15);
    check("popEmpty.unf", 32'(unf_err), 32'h1);
    check("popEmpty.flags", 32'(flags_out), 32'hA);
    applyStimulus("clearErr", 0, 0, 4'h0, 4'h0, 0, 0, 1, 4'd0);
    check("clearErr.unf", 32'(unf_err), 32'h0);
    applyStimulus("push1", 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'd0);
    applyStimulus("push2", 0, 1, 4'hF, 4'h1, 1, 0, 0, 4'd0);
    applyStimulus("pushPop", 0, 1, 4'hF, 4'h9, 1, 1, 0, 4'd0);
    check("pushPop.depth", 32'(depth), 32'h2);
    check("pushPop.unf", 32'(unf_err), 32'h1);
    check("pushPop.flags", 32'(flags_out), 32'h9);
    applyStimulus("clrSet", 0, 0, 4'h0, 4'h0, 1, 1, 1, 4'd0);
    check("clrSet.unf", 32'(unf_err), 32'h1);

    // Condition sweep over every NZCV pattern and every code
    for (int fl = 0; fl < 16; fl++) begin
      applyStimulus("condLd", 0, 1, 4'hF, 4'(fl), 0, 0, 0, 4'd0);
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        check($sformatf("cond.f%0h.c%0d", fl, c), 32'(cond_true), 32'(condRef(mFlags, cond)));
      end
    end
    // Spot check with N=1, V=0, Z=0
    applyStimulus("spot", 0, 1, 4'hF, 4'b0010, 0, 0, 0, 4'd10);
    check("spot.GE", 32'(cond_true), 32'h0);
    cond = 4'd11; #1; check("spot.LT", 32'(cond_true), 32'h1);
    cond = 4'd12; #1; check("spot.GT", 32'(cond_true), 32'h0);
    cond = 4'd13; #1; check("spot.LE", 32'(cond_true), 32'h1);

    // Reset mid-stack, then pop must not restore stale contents
    applyStimulus("midRst0", 1, 0, 4'h0, 4'h0, 0, 0, 0, 4'd0);
    applyStimulus("midLd", 0, 1, 4'hF, 4'h7, 0, 0, 0, 4'd0);
    applyStimulus("midP1", 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'd0);
    applyStimulus("midP2", 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'd0);
    applyStimulus("midP3", 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'd0);
    check("midP3.depth", 32'(depth), 32'h3);
    applyStimulus("midRst", 1, 1, 4'hF, 4'hF, 1, 0, 0, 4'd0);
    check("midRst.depth", 32'(depth), 32'h0);
    check("midRst.flags", 32'(flags_out), 32'h0);
    applyStimulus("midPop", 0, 0, 4'h0, 4'h0, 0, 1, 0, 4'd0);
    check("midPop.unf", 32'(unf_err), 32'h1);
    check("midPop.flags", 32'(flags_out), 32'h0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 1)),
                    4'($urandom), 4'($urandom),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 7) == 0),
                    4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
